// File: rtl/gru_sequence_ctrl.sv
// gru_sequence_ctrl: steps a gruCell through a SEQ_LEN frame sequence,
// holding cell inputs for CELL_LATENCY cycles and emitting the final h.
module gru_sequence_ctrl #(
    parameter int WIDTH        = 11,
    parameter int x_SIZE       = 6,
    parameter int h_SIZE       = 120,
    parameter int SEQ_LEN      = 20,
    parameter int CELL_LATENCY = 18,
    localparam int SW = $clog2(SEQ_LEN + 1),
    localparam int CW = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [x_SIZE-1:0][WIDTH-1:0]   x_in,
    output logic [x_SIZE-1:0][WIDTH-1:0]   cell_x_t,
    output logic [h_SIZE-1:0][WIDTH-1:0]   cell_h_t_minus_1,
    input  logic [h_SIZE-1:0][WIDTH-1:0]   cell_h_t,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [h_SIZE-1:0][WIDTH-1:0]   h_out,
    output logic [SW-1:0]                  step,
    output logic                           busy
);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        RUN    = 2'd1,
        OUT    = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CELL_LATENCY - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(SEQ_LEN - 1);

    state_t                         state_q, state_d;
    logic [x_SIZE-1:0][WIDTH-1:0]   x_q, x_d;
    logic [h_SIZE-1:0][WIDTH-1:0]   h_q, h_d;
    logic [SW-1:0]                  step_q, step_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           live_q;

    // Handshake outputs; in_ready is held low until the first clock after reset.
    assign in_ready         = live_q && (state_q == ACCEPT);
    assign out_valid        = (state_q == OUT);
    assign busy             = (state_q == RUN) || (state_q == OUT);
    assign cell_x_t         = x_q;
    assign cell_h_t_minus_1 = h_q;
    assign h_out            = h_q;
    assign step             = step_q;

    // State, data and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACCEPT;
            x_q     <= '0;
            h_q     <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            h_q     <= h_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end

    // Next-state logic; clear overrides any coincident handshake.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        h_d     = h_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ACCEPT: begin
                if (in_valid && in_ready) begin
                    x_d     = x_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    h_d     = cell_h_t;
                    step_d  = step_q + SW'(1);
                    state_d = (step_q == STEP_LAST) ? OUT : ACCEPT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    h_d     = '0;
                    step_d  = '0;
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
        if (clear) begin
            state_d = ACCEPT;
            x_d     = x_q;
            h_d     = '0;
            step_d  = '0;
            cnt_d   = '0;
        end
    end

endmodule

// File: tb/tb_gru_sequence_ctrl.sv
// tb_gru_sequence_ctrl: scoreboard bench driving the sequencer against a
// latency-4 accumulate cell model (h_t = h_t_minus_1 + x_t[0]).
module tb_gru_sequence_ctrl;

    localparam int WIDTH = 11;
    localparam int XS    = 6;
    localparam int HS    = 8;
    localparam int SL    = 3;
    localparam int LAT   = 4;
    localparam int SW    = $clog2(SL + 1);

    logic clk = 1'b0;
    logic reset, clear, in_valid, out_ready;
    logic in_ready, out_valid, busy;
    logic [XS-1:0][WIDTH-1:0] x_in, cell_x_t;
    logic [HS-1:0][WIDTH-1:0] cell_h_t_minus_1, cell_h_t, h_out;
    logic [SW-1:0] step;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [HS-1:0][WIDTH-1:0] sb[$];

    gru_sequence_ctrl #(
        .WIDTH(WIDTH), .x_SIZE(XS), .h_SIZE(HS),
        .SEQ_LEN(SL), .CELL_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .cell_x_t(cell_x_t), .cell_h_t_minus_1(cell_h_t_minus_1),
        .cell_h_t(cell_h_t), .out_valid(out_valid), .out_ready(out_ready),
        .h_out(h_out), .step(step), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cell model: three register stages behind a combinational add.
    logic [HS-1:0][WIDTH-1:0] sum;
    logic [HS-1:0][WIDTH-1:0] pipe [LAT-1];
    always_comb begin
        sum = '0;
        for (int k = 0; k < HS; k++)
            sum[k] = cell_h_t_minus_1[k] + cell_x_t[0];
    end
    always @(posedge clk) begin
        pipe[0] <= sum;
        for (int s = 1; s < LAT - 1; s++) pipe[s] <= pipe[s-1];
    end
    assign cell_h_t = pipe[LAT-2];

    function automatic logic [HS-1:0][WIDTH-1:0] hv(input int v);
        logic [HS-1:0][WIDTH-1:0] r;
        for (int k = 0; k < HS; k++) r[k] = WIDTH'(v);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares presented output against scoreboard, and checks
    // cell inputs never move while a step is running.
    logic in_run_prev = 1'b0;
    logic [XS-1:0][WIDTH-1:0] snap_x;
    logic [HS-1:0][WIDTH-1:0] snap_h;
    always @(negedge clk) begin
        if (!reset) begin
            in_run_prev <= 1'b0;
        end else begin
            if (out_valid) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_unexpected: got h_out[0]=%0d expected no output",
                             h_out[0]);
                end else begin
                    if (h_out !== sb[0]) begin
                        n_bad++;
                        $display("FAIL h_out: got %h expected %h", h_out, sb[0]);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (busy && !out_valid) begin
                if (in_run_prev) begin
                    n_vec++;
                    if (cell_x_t !== snap_x || cell_h_t_minus_1 !== snap_h) begin
                        n_bad++;
                        $display("FAIL run_stable: got x0=%0d h0=%0d expected x0=%0d h0=%0d",
                                 cell_x_t[0], cell_h_t_minus_1[0], snap_x[0], snap_h[0]);
                    end
                end
                snap_x      <= cell_x_t;
                snap_h      <= cell_h_t_minus_1;
                in_run_prev <= 1'b1;
            end else begin
                in_run_prev <= 1'b0;
            end
        end
    end

    // Offer one frame; returns the cycle number of the accepting edge.
    task automatic send(input int v, output int acc);
        bit done = 0;
        acc = -1;
        for (int k = 0; k < XS; k++) x_in[k] = WIDTH'(v);
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready) done = 1;
            @(posedge clk); #1;
            if (done) acc = cyc;
        end
        in_valid = 1'b0;
        check("accept_timeout", int'(done), 1);
    endtask

    // Wait for the step to complete, then check the step count.
    task automatic wait_step(input int exp);
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            if (in_ready || out_valid) done = 1;
        end
        check("step_timeout", int'(done), 1);
        check("step", int'(step), exp);
    endtask

    // Hold off the output for n cycles, then take it.
    task automatic drain(input int n);
        check("out_valid_up", int'(out_valid), 1);
        for (int i = 0; i < n; i++) begin
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_in_ready", int'(in_ready), 1);
        check("post_step", int'(step), 0);
        check("post_out_valid", int'(out_valid), 0);
    endtask

    task automatic run_seq(input int a, input int b, input int c);
        int t;
        send(a, t); wait_step(1);
        send(b, t); wait_step(2);
        send(c, t); wait_step(3);
    endtask

    initial begin
        int t0, t;
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; x_in = '0;
        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_h_out0", int'(h_out[0]), 0);
        check("rst_step", int'(step), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", int'(in_ready), 1);

        // Back-to-back frames 1,2,3 with latency and backpressure checks.
        sb.push_back(hv(6));
        send(1, t0); wait_step(1);
        send(2, t);  wait_step(2);
        send(3, t);  wait_step(3);
        check("out_latency_edges", cyc - t0, 14);
        drain(7);

        // Input stall of 10 cycles after frame 1.
        sb.push_back(hv(6));
        send(1, t); wait_step(1);
        for (int i = 0; i < 10; i++) begin
            check("stall_in_ready", int'(in_ready), 1);
            check("stall_h_reg", int'(cell_h_t_minus_1[0]), 1);
            @(posedge clk); #1;
        end
        send(2, t); wait_step(2);
        send(3, t); wait_step(3);
        drain(0);

        // Restart: h must start from zero again.
        sb.push_back(hv(15));
        run_seq(5, 5, 5);
        drain(0);

        // Clear during step 2 at cnt=2.
        send(1, t); wait_step(1);
        send(2, t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr_in_ready", int'(in_ready), 1);
        check("clr_busy", int'(busy), 0);
        check("clr_step", int'(step), 0);
        check("clr_h_zero", int'(cell_h_t_minus_1 == '0), 1);
        check("clr_out_valid", int'(out_valid), 0);
        sb.push_back(hv(6));
        run_seq(1, 2, 3);
        drain(0);

        // Async reset pulse in the middle of a step.
        send(2, t);
        @(posedge clk); #1;
        #3 reset = 1'b0;
        #1;
        check("arst_in_ready", int'(in_ready), 0);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_h_zero", int'(cell_h_t_minus_1 == '0), 1);
        check("arst_step", int'(step), 0);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        check("arst_rel_ready", int'(in_ready), 1);

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
